uart_tx_8n1: RTL and testbench

//  UART transmitter, 8 data bits, no parity, LSB first. Counterpart of the receive path

---
 rtl/uart_tx_8n1.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_8n1.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_8n1.sv
// UART transmitter, 8N1 (optionally 2 stop bits), LSB first.
// A one-deep holding register lets the next byte be queued while a frame is
// on the line, so consecutive frames go out back-to-back with no idle gap.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    // The baud counter must also span the whole stop period, which may be
    // longer than one bit when two stop bits are configured.
    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int CNT_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;

    logic             accept;
    logic             drain;
    logic             baud_last;

    // Handshake and end-of-period detection for the current state.
    always_comb begin
        accept    = tx_valid && !hold_full_q;
        baud_last = (state_q == STOP) ? (baud_q == STOP_LAST)
                                      : (baud_q == BIT_LAST);
    end

    // Next-state logic for the frame FSM, baud counter, bit index and shifter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        drain     = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (hold_full_q) begin
                    drain   = 1'b1;
                    state_d = START;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    // A queued byte starts its frame on the very edge the
                    // stop period ends, so there is no idle gap.
                    if (hold_full_q) begin
                        drain   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // Only a drain touches the shifter; new accepts go to the holding
        // register and never disturb the byte being sent.
        if (drain) begin
            shift_d = hold_q;
        end
    end

    // Holding register: an accept wins over a drain on the same edge.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (drain) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Line level for the next cycle, derived from where the FSM is going so
    // the registered output lines up exactly with state entry.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Control state with asynchronous reset; the line is forced idle at once.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
        end
    end

    // Data registers carry no reset; their contents are qualified by the
    // holding-full flag and the FSM state.
    always_ff @(posedge CLOCK_50) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = done_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: two instances (1 and 2 stop bits, 4 clocks per bit).
// Stimulus pushes expected bytes into a queue; a line monitor decodes each
// frame cycle by cycle and pops/compares.
module tb_uart_tx_8n1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;

    logic       v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    logic       r1, r2, b1, b2, dn1, dn2, txd1, txd2;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_cnt  = 0;

    logic [7:0] exp_q[$];
    int         start_t[$];
    int         done_t[$];

    logic        mon_active = 1'b0;
    int          mon_cyc    = 0;
    logic        done_due   = 1'b0;
    logic [7:0]  cur_byte   = 8'h00;
    logic [10:0] obs_line   = '0;
    logic [10:0] last_line  = '0;
    int          ferr       = 0;
    int          spurious_done  = 0;
    int          spurious_start = 0;

    uart_tx_8n1 #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .tx_valid (v1),
        .tx_data  (d1),
        .tx_ready (r1),
        .tx_busy  (b1),
        .tx_done  (dn1),
        .uart_txd (txd1)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .tx_valid (v2),
        .tx_data  (d2),
        .tx_ready (r2),
        .tx_busy  (b2),
        .tx_done  (dn2),
        .uart_txd (txd2)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Line monitor: samples the selected instance on the falling clock edge.
    initial begin
        logic mtxd, mdone, mbusy, e;
        int   fl, idx;
        forever begin
            @(negedge clk);
            mtxd  = sel ? txd2 : txd1;
            mdone = sel ? dn2  : dn1;
            mbusy = sel ? b2   : b1;
            fl    = sel ? 44 : 40;
            if (!reset_n) begin
                mon_active = 1'b0;
                done_due   = 1'b0;
            end else begin
                if (done_due) begin
                    chk("done_pulse", {31'd0, mdone}, 32'd1);
                    done_t.push_back(cyc_cnt);
                    done_due = 1'b0;
                end else if (mdone) begin
                    spurious_done = spurious_done + 1;
                end
                if (!mon_active && mtxd == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        spurious_start = spurious_start + 1;
                    end else begin
                        cur_byte   = exp_q.pop_front();
                        start_t.push_back(cyc_cnt);
                        mon_active = 1'b1;
                        mon_cyc    = 0;
                        ferr       = 0;
                        obs_line   = '0;
                    end
                end
                if (mon_active) begin
                    idx = mon_cyc / 4;
                    if (idx == 0)      e = 1'b0;
                    else if (idx <= 8) e = cur_byte[idx-1];
                    else               e = 1'b1;
                    if (mtxd !== e || mbusy !== 1'b1) ferr = ferr + 1;
                    if (mon_cyc % 4 == 2) obs_line[idx] = mtxd;
                    if (mon_cyc == fl - 1) begin
                        chk("frame_byte", {24'd0, obs_line[8:1]}, {24'd0, cur_byte});
                        chk("frame_shape_errs", ferr, 0);
                        last_line  = obs_line;
                        mon_active = 1'b0;
                        done_due   = 1'b1;
                    end
                    mon_cyc = mon_cyc + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [7:0] b, input logic push);
        logic ok;
        ok = 1'b0;
        if (push) exp_q.push_back(b);
        if (s) begin v2 = 1'b1; d2 = b; end
        else   begin v1 = 1'b1; d1 = b; end
        for (int n = 0; n < 200; n++) begin
            if ((s ? r2 : r1) == 1'b1) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        v1 = 1'b0;
        v2 = 1'b0;
        if (!ok) chk("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            step();
            if (!mon_active && !done_due && exp_q.size() == 0 &&
                (sel ? b2 : b1) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) step();
    endtask

    initial begin
        int txd_lo, rdy_lo, busy_hi, done_hi, rdy_hi;
        logic got;

        // Reset state of both instances
        repeat (3) step();
        chk("rst_txd1", {31'd0, txd1}, 32'd1);
        chk("rst_ready1", {31'd0, r1}, 32'd1);
        chk("rst_busy1", {31'd0, b1}, 32'd0);
        chk("rst_done1", {31'd0, dn1}, 32'd0);
        chk("rst_txd2", {31'd0, txd2}, 32'd1);
        chk("rst_ready2", {31'd0, r2}, 32'd1);
        reset_n = 1'b1;

        // Idle for 100 cycles
        txd_lo = 0; rdy_lo = 0; busy_hi = 0; done_hi = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (txd1 !== 1'b1) txd_lo++;
            if (r1 !== 1'b1)   rdy_lo++;
            if (b1 !== 1'b0)   busy_hi++;
            if (dn1 !== 1'b0)  done_hi++;
        end
        chk("idle_txd_low_cycles", txd_lo, 0);
        chk("idle_ready_low_cycles", rdy_lo, 0);
        chk("idle_busy_cycles", busy_hi, 0);
        chk("idle_done_cycles", done_hi, 0);

        // Single frame 8'hA5
        start_t.delete(); done_t.delete();
        send(1'b0, 8'hA5, 1'b1);
        wait_idle();
        chk("a5_line_bits", {21'd0, last_line[9:0]}, 32'h34A);
        if (start_t.size() >= 1 && done_t.size() >= 1)
            chk("a5_done_latency", done_t[0] - start_t[0], 40);
        else
            chk("a5_timestamps", 32'd0, 32'd1);

        // Back-to-back 8'h00 then 8'hFF
        start_t.delete(); done_t.delete();
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'hFF, 1'b1);
        chk("b2b_ready_after_queue", {31'd0, r1}, 32'd0);
        wait_idle();
        if (start_t.size() >= 2 && done_t.size() >= 2) begin
            chk("b2b_no_gap", start_t[1] - done_t[0], 0);
            chk("b2b_done_spacing", done_t[1] - done_t[0], 40);
        end else begin
            chk("b2b_timestamps", 32'd0, 32'd1);
        end

        // Hold tx_valid with 8'h3C while the holding register is full
        send(1'b0, 8'hC3, 1'b1);
        exp_q.push_back(8'h3C);
        v1 = 1'b1; d1 = 8'h3C;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (r1) begin got = 1'b1; step(); break; end
            step();
        end
        chk("hold_first_accept", {31'd0, got}, 32'd1);
        rdy_hi = 0;
        for (int i = 0; i < 25; i++) begin
            if (r1) rdy_hi++;
            step();
        end
        v1 = 1'b0;
        chk("hold_ready_stays_low", rdy_hi, 0);
        wait_idle();

        // Two stop bits, 8'h81
        sel = 1'b1;
        repeat (2) step();
        start_t.delete(); done_t.delete();
        send(1'b1, 8'h81, 1'b1);
        wait_idle();
        chk("sb2_line_bits", {21'd0, last_line}, 32'h702);
        if (start_t.size() >= 1 && done_t.size() >= 1)
            chk("sb2_frame_len", done_t[0] - start_t[0], 44);
        else
            chk("sb2_timestamps", 32'd0, 32'd1);
        sel = 1'b0;
        repeat (2) step();

        // Reset during data bit 3 of 8'h55 with 8'hEE queued
        send(1'b0, 8'h55, 1'b1);
        send(1'b0, 8'hEE, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (mon_active && mon_cyc >= 17) begin got = 1'b1; break; end
        end
        chk("mid_reach_bit3", {31'd0, got}, 32'd1);
        chk("mid_bit3_low", {31'd0, txd1}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_txd", {31'd0, txd1}, 32'd1);
        chk("mid_rst_busy", {31'd0, b1}, 32'd0);
        chk("mid_rst_ready", {31'd0, r1}, 32'd1);
        repeat (3) step();
        reset_n = 1'b1;
        txd_lo = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (txd1 !== 1'b1) txd_lo++;
        end
        chk("post_rst_line_idle", txd_lo, 0);
        start_t.delete(); done_t.delete();
        send(1'b0, 8'h12, 1'b1);
        wait_idle();
        if (start_t.size() >= 1 && done_t.size() >= 1)
            chk("post_rst_frame_len", done_t[0] - start_t[0], 40);
        else
            chk("post_rst_timestamps", 32'd0, 32'd1);

        chk("spurious_done", spurious_done, 0);
        chk("spurious_start", spurious_start, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
